iob_pcie_rx_ctrl: RTL and testbench
===================================

// Module: iob_pcie_rx_ctrl
// PURPOSE
//  RX-channel transaction controller between the PCIe channel RX pins and the
//  iob_pcie RX FIFO write port. Accepts one channel transaction at a time and
//  pulses ACK. Counts incoming 64-bit beats against CHNL_RX_LEN (4-byte
//  words), drives REN through a 1-entry output register slice, and reports
//  done / truncation status to the CPU-side register bank.
// PARAMETERS
//  DATA_W            32  width of LEN field, beat counter and latched length
//  C_PCI_DATA_WIDTH  64  channel data width; fixed at 2 words per beat
// PORTS
//  clk                    in   1       system clock; the only clock
//  rst_n                  in   1       asynchronous reset, active low
//  chnl_rx_i              in   1       transaction in progress
//  chnl_rx_last_i         in   1       last transaction of sequence
//  chnl_rx_len_i          in   DATA_W  length in 32-bit words
//  chnl_rx_data_i         in   64      receive data
//  chnl_rx_data_valid_i   in   1       chnl_rx_data_i valid
//  chnl_rx_data_ren_o     out  1       consume current data beat
//  chnl_rx_ack_o          out  1       transaction acknowledge pulse
//  m_valid_o              out  1       output beat valid (to FIFO write)
//  m_data_o               out  64      output beat data
//  m_keep_o               out  2       word enables: [0]=bits 31:0, [1]=63:32
//  m_last_o               out  1       final beat of transaction
//  m_ready_i              in   1       FIFO not full (beat accepted if valid&ready)
//  busy_o                 out  1       state != IDLE
//  done_o                 out  1       1-cycle pulse: transaction completed
//  err_o                  out  1       sticky: chnl_rx_i dropped before LEN reached
//  len_o                  out  DATA_W  latched LEN of current/last transaction
//  last_o                 out  1       latched chnl_rx_last_i
// BEHAVIOUR
//  Reset: all outputs 0. State IDLE, counters 0, output slice empty.
//  Reset mid-transaction aborts immediately. No ACK/done is issued afterwards.
//  beats = (len+1)>>1, computed at DATA_W+1 bits (len=0xFFFFFFFF -> 0x80000000).
//  IDLE: on chnl_rx_i=1, latch len_o, last_o and beats; clear err_o.
//    Assert chnl_rx_ack_o for exactly 1 cycle (the next cycle).
//    Next state is RECV, or DONE if len==0.
//  RECV: ren_o = ~m_valid_o | m_ready_i.
//    Accept happens when ren_o & data_valid_i; the beat loads the slice on the
//    next clk and the beat counter increments.
//    Slice holds data while m_valid_o & ~m_ready_i. No beat is lost or duplicated.
//    Accepting and draining in the same cycle is legal (full throughput).
//    When the accepted count reaches beats, ren_o drops in the same cycle
//    (combinational on count), and the state goes to DONE.
//    chnl_rx_i=0 before count reached: set err_o, assert m_last_o on the
//    held/next beat if any, and go to DONE.
//  DONE: ren_o=0. When the slice is empty, pulse done_o for 1 cycle.
//    Then wait for chnl_rx_i=0 and go to IDLE.
//    A new transaction must see chnl_rx_i low for >=1 cycle first.
//  m_last_o=1 with the beat whose index is beats-1.
//  m_keep_o=2'b11, except the last beat of an odd len, which is 2'b01.
//  Extra data_valid beyond len: never consumed (ren_o=0).
//  ACK is never sent twice per transaction.
//  data_valid without chnl_rx_i in IDLE: ignored, ren_o=0.
//  Latency: beat on pins to m_valid_o is 1 cycle. chnl_rx_i rise to ack is 1 cycle.
// TESTING
//  len=8, valid every cycle, ready=1 -> ack 1 cycle at T+1; 4 beats;
//    keep=11; last on beat 3; done pulse; err=0.
//  len=5 -> 3 beats, beat 2 keep=01 last=1; len_o=5.
//  len=0 -> ack, no ren, done pulse, m_valid_o never high.
//  len=16, m_ready_i toggles 1/0 each cycle -> 8 beats in order, none dup/lost;
//    data held stable while ~ready.
//  len=16, chnl_rx_i drops after 3 beats -> err_o=1; last on beat 2; done pulse;
//    err_o clears at next chnl_rx_i rise.
//  rst_n low during RECV after 2 beats -> all outputs 0 at once;
//    next transaction (len=4) completes normally.

Source files
------------

// File: rtl/iob_pcie_rx_ctrl.sv
// ---------------------------------------------------------------------------
// iob_pcie_rx_ctrl
// RX-channel transaction controller. Takes one PCIe channel RX transaction at
// a time, acknowledges it, consumes 64-bit beats up to the requested length
// (in 32-bit words), and forwards them through a 1-entry register slice to
// the RX FIFO write port. It reports done/truncation status to the CPU side.
//
// Ports
//   clk, rst_n              clock, async active-low reset
//   chnl_rx_i               transaction in progress
//   chnl_rx_last_i          last transaction of the sequence
//   chnl_rx_len_i           transaction length in 32-bit words
//   chnl_rx_data_i          receive data beat
//   chnl_rx_data_valid_i    receive data valid
//   chnl_rx_data_ren_o      consume current beat
//   chnl_rx_ack_o           1-cycle transaction acknowledge
//   m_valid_o/m_data_o/m_keep_o/m_last_o, m_ready_i   FIFO write port
//   busy_o                  controller not idle
//   done_o                  1-cycle pulse when the transaction completes
//   err_o                   sticky: transaction ended before its length
//   len_o, last_o           latched length / last flag
// ---------------------------------------------------------------------------
module iob_pcie_rx_ctrl #(
    parameter int DATA_W           = 32,
    parameter int C_PCI_DATA_WIDTH = 64
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        chnl_rx_i,
    input  logic                        chnl_rx_last_i,
    input  logic [DATA_W-1:0]           chnl_rx_len_i,
    input  logic [C_PCI_DATA_WIDTH-1:0] chnl_rx_data_i,
    input  logic                        chnl_rx_data_valid_i,
    output logic                        chnl_rx_data_ren_o,
    output logic                        chnl_rx_ack_o,
    output logic                        m_valid_o,
    output logic [C_PCI_DATA_WIDTH-1:0] m_data_o,
    output logic [1:0]                  m_keep_o,
    output logic                        m_last_o,
    input  logic                        m_ready_i,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        err_o,
    output logic [DATA_W-1:0]           len_o,
    output logic                        last_o
);

    typedef enum logic [1:0] {S_IDLE, S_RECV, S_DONE} state_t;

    state_t                      state_q, state_d;
    logic [DATA_W-1:0]           len_q, len_d;
    logic [DATA_W-1:0]           beats_q, beats_d;
    logic [DATA_W-1:0]           cnt_q, cnt_d;
    logic                        last_q, last_d;
    logic                        err_q, err_d;
    logic                        ack_q, ack_d;
    logic                        done_sent_q, done_sent_d;
    logic                        armed_q, armed_d;

    // output register slice
    logic                        vld_q, vld_d;
    logic [C_PCI_DATA_WIDTH-1:0] data_q, data_d;
    logic [1:0]                  keep_q, keep_d;
    logic                        slast_q, slast_d;

    logic [DATA_W:0]             len_p1;
    logic                        is_last_beat;
    logic                        ren;
    logic                        accept;
    logic                        trunc;
    logic                        done_pulse;

    // beats = (len+1)>>1 with one extra bit so len=all-ones does not wrap
    assign len_p1       = {1'b0, chnl_rx_len_i} + {{DATA_W{1'b0}}, 1'b1};
    assign is_last_beat = (cnt_q == beats_q - {{(DATA_W-1){1'b0}}, 1'b1});

    // Reading stops combinationally once the count is met; gating with
    // chnl_rx_i keeps a beat from being taken in the cycle the channel aborts.
    assign ren    = (state_q == S_RECV) && chnl_rx_i && (cnt_q != beats_q) &&
                    (!vld_q || m_ready_i);
    assign accept = ren && chnl_rx_data_valid_i;
    assign trunc  = (state_q == S_RECV) && !chnl_rx_i && (cnt_q != beats_q);

    // done only once the slice has drained, and only once per transaction
    assign done_pulse = (state_q == S_DONE) && !vld_q && !done_sent_q;

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        beats_d     = beats_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        err_d       = err_q;
        ack_d       = 1'b0;
        done_sent_d = done_sent_q;
        armed_d     = armed_q;
        vld_d       = vld_q;
        data_d      = data_q;
        keep_d      = keep_q;
        slast_d     = slast_q;

        if (accept) begin
            vld_d   = 1'b1;
            data_d  = chnl_rx_data_i;
            keep_d  = (is_last_beat && len_q[0]) ? 2'b01 : 2'b11;
            slast_d = is_last_beat;
        end else if (m_ready_i) begin
            vld_d   = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                // a start needs chnl_rx_i seen low first, so a level left high
                // across reset or a finished transaction is not re-acked
                if (!chnl_rx_i) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    armed_d     = 1'b0;
                    len_d       = chnl_rx_len_i;
                    last_d      = chnl_rx_last_i;
                    beats_d     = len_p1[DATA_W:1];
                    cnt_d       = '0;
                    err_d       = 1'b0;
                    ack_d       = 1'b1;
                    done_sent_d = 1'b0;
                    state_d     = (chnl_rx_len_i == '0) ? S_DONE : S_RECV;
                end
            end
            S_RECV: begin
                if (accept) begin
                    cnt_d = cnt_q + {{(DATA_W-1){1'b0}}, 1'b1};
                    if (is_last_beat) state_d = S_DONE;
                end else if (trunc) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (done_pulse) done_sent_d = 1'b1;
                if ((done_sent_q || done_pulse) && !chnl_rx_i) begin
                    armed_d = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            beats_q     <= '0;
            cnt_q       <= '0;
            last_q      <= 1'b0;
            err_q       <= 1'b0;
            ack_q       <= 1'b0;
            done_sent_q <= 1'b0;
            armed_q     <= 1'b0;
            vld_q       <= 1'b0;
            data_q      <= '0;
            keep_q      <= '0;
            slast_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            beats_q     <= beats_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            err_q       <= err_d;
            ack_q       <= ack_d;
            done_sent_q <= done_sent_d;
            armed_q     <= armed_d;
            vld_q       <= vld_d;
            data_q      <= data_d;
            keep_q      <= keep_d;
            slast_q     <= slast_d;
        end
    end

    assign chnl_rx_data_ren_o = ren;
    assign chnl_rx_ack_o      = ack_q;
    assign m_valid_o          = vld_q;
    assign m_data_o           = data_q;
    assign m_keep_o           = keep_q;
    // on truncation the beat still in the slice becomes the final one
    assign m_last_o           = vld_q && (slast_q || err_q || trunc);
    assign busy_o             = (state_q != S_IDLE);
    assign done_o             = done_pulse;
    assign err_o              = err_q;
    assign len_o              = len_q;
    assign last_o             = last_q;

endmodule

// File: tb/tb_iob_pcie_rx_ctrl.sv
module tb_iob_pcie_rx_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        chnl_rx_i;
    logic        chnl_rx_last_i;
    logic [31:0] chnl_rx_len_i;
    logic [63:0] chnl_rx_data_i;
    logic        chnl_rx_data_valid_i;
    logic        chnl_rx_data_ren_o;
    logic        chnl_rx_ack_o;
    logic        m_valid_o;
    logic [63:0] m_data_o;
    logic [1:0]  m_keep_o;
    logic        m_last_o;
    logic        m_ready_i;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    logic [31:0] len_o;
    logic        last_o;

    iob_pcie_rx_ctrl #(.DATA_W(32), .C_PCI_DATA_WIDTH(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .chnl_rx_i(chnl_rx_i), .chnl_rx_last_i(chnl_rx_last_i),
        .chnl_rx_len_i(chnl_rx_len_i), .chnl_rx_data_i(chnl_rx_data_i),
        .chnl_rx_data_valid_i(chnl_rx_data_valid_i),
        .chnl_rx_data_ren_o(chnl_rx_data_ren_o), .chnl_rx_ack_o(chnl_rx_ack_o),
        .m_valid_o(m_valid_o), .m_data_o(m_data_o), .m_keep_o(m_keep_o),
        .m_last_o(m_last_o), .m_ready_i(m_ready_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .len_o(len_o), .last_o(last_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] data;
        logic [1:0]  keep;
        logic        last;
    } beat_t;

    beat_t       exp_q[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          ack_cnt = 0;
    int          done_cnt = 0;
    int          ack_cyc = 0;
    bit          prev_stall = 0;
    logic [63:0] prev_data = '0;
    beat_t       mon_e;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // expected beat i of a transaction of len words, straight from the word count
    function automatic beat_t mk_beat(input int i, input int len, input logic [63:0] d);
        beat_t b;
        int    nb;
        nb     = (len + 1) / 2;
        b.data = d;
        b.last = (i == nb - 1);
        b.keep = (i == nb - 1 && (len % 2) == 1) ? 2'b01 : 2'b11;
        return b;
    endfunction

    // monitor: samples one time unit before each rising edge
    initial begin
        forever begin
            @(negedge clk);
            #4;
            if (rst_n) begin
                if (chnl_rx_ack_o) begin
                    ack_cnt++;
                    ack_cyc = cyc;
                    chk(err_o == 1'b0, "err_clear_on_start", 64'(err_o), 64'd0);
                end
                if (done_o) begin
                    done_cnt++;
                    chk(!m_valid_o && exp_q.size() == 0, "done_after_drain",
                        64'(exp_q.size()), 64'd0);
                end
                if (prev_stall)
                    chk(m_valid_o && m_data_o == prev_data, "hold_stable", m_data_o, prev_data);
                if (m_valid_o && m_ready_i) begin
                    if (exp_q.size() == 0) begin
                        chk(1'b0, "unexpected_beat", m_data_o, 64'd0);
                    end else begin
                        mon_e = exp_q.pop_front();
                        chk(m_data_o == mon_e.data, "beat_data", m_data_o, mon_e.data);
                        chk(m_keep_o == mon_e.keep, "beat_keep", 64'(m_keep_o), 64'(mon_e.keep));
                        chk(m_last_o == mon_e.last, "beat_last", 64'(m_last_o), 64'(mon_e.last));
                    end
                end
                prev_stall = m_valid_o && !m_ready_i;
                prev_data  = m_data_o;
            end else begin
                prev_stall = 0;
            end
        end
    end

    // rmode: 0 ready always, 1 toggling, 2 random; drop_at <0 means no abort
    task automatic run_txn(input int len, input bit lst, input int rmode, input int drop_at, input int vprob);
        int beats, k, a0, d0, rise;
        bit finished, dropped, exp_err;
        beats    = (len + 1) / 2;
        k        = 0;
        a0       = ack_cnt;
        d0       = done_cnt;
        finished = 0;
        dropped  = 0;
        exp_err  = 0;
        @(negedge clk);
        chnl_rx_i      = 1'b1;
        chnl_rx_len_i  = 32'(len);
        chnl_rx_last_i = lst;
        rise           = cyc;
        for (int c = 0; c < 2000 && !finished; c++) begin
            case (rmode)
                0:       m_ready_i = 1'b1;
                1:       m_ready_i = (c % 2 == 0);
                default: m_ready_i = 1'($urandom_range(0, 1));
            endcase
            chnl_rx_data_i       = {$urandom, $urandom};
            chnl_rx_data_valid_i = chnl_rx_i && ($urandom_range(0, 99) < vprob);
            if (drop_at >= 0 && !dropped && c >= 2 && k >= drop_at) begin
                dropped              = 1;
                chnl_rx_i            = 1'b0;
                chnl_rx_data_valid_i = 1'b0;
                if (k < beats) begin
                    exp_err = 1;
                    if (exp_q.size() > 0) exp_q[$].last = 1'b1;
                end
            end
            if (done_cnt > d0) begin
                chnl_rx_i            = 1'b0;
                chnl_rx_data_valid_i = 1'b0;
            end
            #2;
            if (chnl_rx_data_ren_o && chnl_rx_data_valid_i) begin
                if (k >= beats) chk(1'b0, "no_overconsume", 64'(k), 64'(beats));
                else            exp_q.push_back(mk_beat(k, len, chnl_rx_data_i));
                k++;
            end
            if (!chnl_rx_i && !busy_o && done_cnt > d0) finished = 1;
            @(negedge clk);
        end
        chk(finished, "txn_complete", 64'(finished), 64'd1);
        m_ready_i = 1'b1;
        repeat (2) @(negedge clk);
        chk(ack_cnt - a0 == 1, "ack_count", 64'(ack_cnt - a0), 64'd1);
        chk(ack_cyc - rise == 1, "ack_latency", 64'(ack_cyc - rise), 64'd1);
        chk(done_cnt - d0 == 1, "done_count", 64'(done_cnt - d0), 64'd1);
        chk(err_o == exp_err, "err_status", 64'(err_o), 64'(exp_err));
        chk(len_o == 32'(len), "len_latched", 64'(len_o), 64'(len));
        chk(last_o == lst, "last_latched", 64'(last_o), 64'(lst));
        chk(exp_q.size() == 0, "all_beats_out", 64'(exp_q.size()), 64'd0);
        if (!exp_err)
            chk(k == beats, "beats_consumed", 64'(k), 64'(beats));
    endtask

    task automatic reset_mid();
        int k, a0, d0;
        k = 0;
        @(negedge clk);
        chnl_rx_i      = 1'b1;
        chnl_rx_len_i  = 32'd16;
        chnl_rx_last_i = 1'b0;
        m_ready_i      = 1'b1;
        for (int c = 0; c < 50 && k < 2; c++) begin
            chnl_rx_data_i       = {$urandom, $urandom};
            chnl_rx_data_valid_i = 1'b1;
            #2;
            if (chnl_rx_data_ren_o && chnl_rx_data_valid_i) begin
                exp_q.push_back(mk_beat(k, 16, chnl_rx_data_i));
                k++;
            end
            @(negedge clk);
        end
        chk(k == 2 && busy_o, "reset_setup", 64'(k), 64'd2);
        rst_n                = 1'b0;
        chnl_rx_i            = 1'b0;
        chnl_rx_data_valid_i = 1'b0;
        #1;
        chk({chnl_rx_data_ren_o, chnl_rx_ack_o, m_valid_o, m_data_o, m_keep_o, m_last_o,
             busy_o, done_o, err_o, len_o, last_o} == '0, "reset_mid_outputs_zero",
            {m_valid_o, busy_o, m_data_o[61:0]}, 64'd0);
        exp_q.delete();
        a0 = ack_cnt;
        d0 = done_cnt;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk(ack_cnt == a0 && done_cnt == d0 && !busy_o, "no_ack_done_after_reset",
            64'(ack_cnt - a0 + done_cnt - d0), 64'd0);
    endtask

    initial begin
        int len, drop;
        rst_n                = 1'b0;
        chnl_rx_i            = 1'b0;
        chnl_rx_last_i       = 1'b0;
        chnl_rx_len_i        = '0;
        chnl_rx_data_i       = '0;
        chnl_rx_data_valid_i = 1'b1;
        m_ready_i            = 1'b1;
        repeat (3) @(negedge clk);
        chk({chnl_rx_data_ren_o, chnl_rx_ack_o, m_valid_o, m_data_o, m_keep_o, m_last_o,
             busy_o, done_o, err_o, len_o, last_o} == '0, "reset_outputs_zero",
            {m_valid_o, busy_o, m_data_o[61:0]}, 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk(chnl_rx_data_ren_o == 1'b0, "idle_ignores_valid", 64'(chnl_rx_data_ren_o), 64'd0);
        chnl_rx_data_valid_i = 1'b0;

        run_txn(8, 1'b0, 0, -1, 100);
        run_txn(5, 1'b1, 0, -1, 100);
        run_txn(0, 1'b0, 0, -1, 100);
        run_txn(16, 1'b0, 1, -1, 100);
        run_txn(16, 1'b1, 0, 3, 100);
        run_txn(6, 1'b0, 2, -1, 60);
        reset_mid();
        run_txn(4, 1'b1, 0, -1, 100);
        for (int i = 0; i < 12; i++) begin
            len  = $urandom_range(0, 21);
            drop = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, (len + 1) / 2)) : -1;
            run_txn(len, 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), drop,
                    int'($urandom_range(40, 100)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
